// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one registered ALU datapath between two
// requesters, waits the datapath latency and returns the result tagged by requester.
module alu_share_arbiter #(
  parameter int N   = 8,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] b0,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b1,
  input  logic         c_in0,
  input  logic         c_in1,
  input  logic         sel0,
  input  logic         sel1,
  output logic         gnt0,
  output logic         gnt1,
  output logic [N-1:0] dp_a,
  output logic [N-1:0] dp_b,
  output logic         dp_c_in,
  output logic         dp_sel,
  input  logic [N-1:0] dp_q,
  output logic [N-1:0] q,
  output logic         q_valid,
  output logic         q_id,
  output logic         busy
);

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t       r_state;
  logic [3:0]   r_cnt;
  logic         r_last;
  logic         r_gnt0;
  logic         r_gnt1;
  logic [N-1:0] r_dp_a;
  logic [N-1:0] r_dp_b;
  logic         r_dp_c_in;
  logic         r_dp_sel;
  logic [N-1:0] r_q;
  logic         r_q_valid;
  logic         r_q_id;
  logic         r_busy;

  logic         w_any;
  logic         w_win;

  assign w_any = req0 | req1;
  // Under contention the requester that did not win last time goes first.
  assign w_win = (req0 & req1) ? ~r_last : req1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_last    <= 1'b1;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_dp_a    <= '0;
      r_dp_b    <= '0;
      r_dp_c_in <= 1'b0;
      r_dp_sel  <= 1'b0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_q_id    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_q_valid <= 1'b0;
          if (w_any) begin
            r_state   <= S_WAIT;
            r_cnt     <= LAT_CNT;
            r_busy    <= 1'b1;
            r_last    <= w_win;
            r_q_id    <= w_win;
            r_gnt0    <= ~w_win;
            r_gnt1    <= w_win;
            r_dp_a    <= w_win ? a1 : a0;
            r_dp_b    <= w_win ? b1 : b0;
            r_dp_c_in <= w_win ? c_in1 : c_in0;
            r_dp_sel  <= w_win ? sel1 : sel0;
          end
        end
        S_WAIT: begin
          r_gnt0 <= 1'b0;
          r_gnt1 <= 1'b0;
          r_cnt  <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_q       <= dp_q;
          r_q_valid <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign dp_a    = r_dp_a;
  assign dp_b    = r_dp_b;
  assign dp_c_in = r_dp_c_in;
  assign dp_sel  = r_dp_sel;
  assign q       = r_q;
  assign q_valid = r_q_valid;
  assign q_id    = r_q_id;
  assign busy    = r_busy;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: two instances (LAT=1 and LAT=3) each with a pipelined
// datapath model, checked cycle by cycle against a transaction-timing reference.
module tb_alu_share_arbiter;

  logic       clk;
  int         cyc;
  int         total;
  int         passed;

  logic [1:0] rst_n;
  logic [1:0] req0, req1, c_in0, c_in1, sel0, sel1;
  logic [7:0] a0 [2];
  logic [7:0] b0 [2];
  logic [7:0] a1 [2];
  logic [7:0] b1 [2];
  logic [1:0] gnt0, gnt1, dp_c_in, dp_sel, q_valid, q_id, busy;
  logic [7:0] dp_a [2];
  logic [7:0] dp_b [2];
  logic [7:0] dp_q [2];
  logic [7:0] q [2];

  // reference model state: timing as absolute cycle numbers
  int         m_free [2];
  int         m_due  [2];
  logic       m_last [2];
  logic [7:0] m_exp  [2];
  logic [7:0] m_q    [2];
  logic       m_qid  [2];
  logic [7:0] m_dpa  [2];
  logic [7:0] m_dpb  [2];
  logic       m_dpc  [2];
  logic       m_dps  [2];
  logic [1:0] hold;
  logic [1:0] autoreq;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic c, input logic s);
    return s ? (a ^ b) : (a + b + 8'(c));
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int L = (g == 0) ? 1 : 3;
    logic [7:0] pipe [L];

    alu_share_arbiter #(.N(8), .LAT(L)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n[g]),
      .req0    (req0[g]),
      .req1    (req1[g]),
      .a0      (a0[g]),
      .b0      (b0[g]),
      .a1      (a1[g]),
      .b1      (b1[g]),
      .c_in0   (c_in0[g]),
      .c_in1   (c_in1[g]),
      .sel0    (sel0[g]),
      .sel1    (sel1[g]),
      .gnt0    (gnt0[g]),
      .gnt1    (gnt1[g]),
      .dp_a    (dp_a[g]),
      .dp_b    (dp_b[g]),
      .dp_c_in (dp_c_in[g]),
      .dp_sel  (dp_sel[g]),
      .dp_q    (dp_q[g]),
      .q       (q[g]),
      .q_valid (q_valid[g]),
      .q_id    (q_id[g]),
      .busy    (busy[g])
    );

    always @(posedge clk) begin
      pipe[0] <= alu_f(dp_a[g], dp_b[g], dp_c_in[g], dp_sel[g]);
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign dp_q[g] = pipe[L-1];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s inst=%0d cyc=%0d observed=%0h expected=%0h", tag, k, cyc, obs, exp);
  endtask

  task automatic model_reset(input int k);
    m_free[k] = 0;
    m_due[k]  = -1;
    m_last[k] = 1'b1;
    m_exp[k]  = '0;
    m_q[k]    = '0;
    m_qid[k]  = 1'b0;
    m_dpa[k]  = '0;
    m_dpb[k]  = '0;
    m_dpc[k]  = 1'b0;
    m_dps[k]  = 1'b0;
  endtask

  task automatic rand_ops(input int k, input int r, input bit rnd_sel);
    if (r == 0) begin
      a0[k] = 8'($urandom); b0[k] = 8'($urandom);
      c_in0[k] = 1'($urandom_range(1)); sel0[k] = rnd_sel ? 1'($urandom_range(1)) : 1'b0;
    end else begin
      a1[k] = 8'($urandom); b1[k] = 8'($urandom);
      c_in1[k] = 1'($urandom_range(1)); sel1[k] = rnd_sel ? 1'($urandom_range(1)) : 1'b0;
    end
  endtask

  // Called just after the falling edge: inputs still hold what the last rising edge saw.
  task automatic check(input int k);
    int   c;
    int   w;
    logic eg0, eg1, ev;
    c = cyc; eg0 = 1'b0; eg1 = 1'b0; ev = 1'b0;
    if (!rst_n[k]) begin
      model_reset(k);
    end else begin
      if (c == m_due[k]) begin
        ev = 1'b1;
        m_q[k] = m_exp[k];
        m_due[k] = -1;
      end
      if (c >= m_free[k] && (req0[k] || req1[k])) begin
        if (req0[k] && req1[k]) w = m_last[k] ? 0 : 1;
        else w = req1[k] ? 1 : 0;
        if (w == 0) begin
          eg0 = 1'b1;
          m_dpa[k] = a0[k]; m_dpb[k] = b0[k]; m_dpc[k] = c_in0[k]; m_dps[k] = sel0[k];
        end else begin
          eg1 = 1'b1;
          m_dpa[k] = a1[k]; m_dpb[k] = b1[k]; m_dpc[k] = c_in1[k]; m_dps[k] = sel1[k];
        end
        m_exp[k]  = alu_f(m_dpa[k], m_dpb[k], m_dpc[k], m_dps[k]);
        m_due[k]  = c + lat(k) + 1;
        m_free[k] = c + lat(k) + 2;
        m_last[k] = (w == 1);
        m_qid[k]  = (w == 1);
      end
    end
    chk("gnt0",    k, 32'(gnt0[k]),    32'(eg0));
    chk("gnt1",    k, 32'(gnt1[k]),    32'(eg1));
    chk("busy",    k, 32'(busy[k]),    32'(c <= m_free[k] - 2));
    chk("q_valid", k, 32'(q_valid[k]), 32'(ev));
    chk("q",       k, 32'(q[k]),       32'(m_q[k]));
    chk("q_id",    k, 32'(q_id[k]),    32'(m_qid[k]));
    chk("dp_a",    k, 32'(dp_a[k]),    32'(m_dpa[k]));
    chk("dp_b",    k, 32'(dp_b[k]),    32'(m_dpb[k]));
    chk("dp_c_in", k, 32'(dp_c_in[k]), 32'(m_dpc[k]));
    chk("dp_sel",  k, 32'(dp_sel[k]),  32'(m_dps[k]));
  endtask

  task automatic react(input int k);
    if (gnt0[k] === 1'b1) begin
      if (hold[k]) rand_ops(k, 0, 1'b0);
      else req0[k] = 1'b0;
    end
    if (gnt1[k] === 1'b1) begin
      if (hold[k]) rand_ops(k, 1, 1'b0);
      else req1[k] = 1'b0;
    end
    if (autoreq[k]) begin
      if (!req0[k] && $urandom_range(2) == 0) begin req0[k] = 1'b1; rand_ops(k, 0, 1'b1); end
      if (!req1[k] && $urandom_range(2) == 0) begin req1[k] = 1'b1; rand_ops(k, 1, 1'b1); end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) check(k);
    for (int k = 0; k < 2; k++) react(k);
  endtask

  task automatic apply_reset(input int k);
    rst_n[k] = 1'b0;
    #1;
    chk("rst_busy",    k, 32'(busy[k]),    32'd0);
    chk("rst_q_valid", k, 32'(q_valid[k]), 32'd0);
    chk("rst_gnt0",    k, 32'(gnt0[k]),    32'd0);
    chk("rst_gnt1",    k, 32'(gnt1[k]),    32'd0);
    model_reset(k);
  endtask

  initial begin
    cyc = 0; total = 0; passed = 0;
    rst_n = '0; req0 = '0; req1 = '0; c_in0 = '0; c_in1 = '0; sel0 = '0; sel1 = '0;
    hold = '0; autoreq = '0;
    for (int k = 0; k < 2; k++) begin
      a0[k] = '0; b0[k] = '0; a1[k] = '0; b1[k] = '0;
      model_reset(k);
    end

    // reset held with random activity on the inputs
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 2; k++) begin
        req0[k] = 1'($urandom_range(1)); req1[k] = 1'($urandom_range(1));
        rand_ops(k, 0, 1'b1); rand_ops(k, 1, 1'b1);
      end
      cycle();
    end
    req0 = '0; req1 = '0; rst_n = '1;
    repeat (3) cycle();

    // single op: 5 + 3 + 1 = 9
    req0[0] = 1'b1; a0[0] = 8'h05; b0[0] = 8'h03; c_in0[0] = 1'b1; sel0[0] = 1'b0;
    repeat (5) cycle();

    // contention from fresh reset on both instances: order 0,1,0,1
    apply_reset(0); apply_reset(1);
    cycle();
    rst_n = '1;
    hold = '1;
    for (int k = 0; k < 2; k++) begin
      req0[k] = 1'b1; req1[k] = 1'b1;
      rand_ops(k, 0, 1'b0); rand_ops(k, 1, 1'b0);
    end
    repeat (22) cycle();
    hold = '0;
    repeat (14) cycle();

    // wrap on requester 1: 0xFF + 0x01 -> 0x00
    for (int k = 0; k < 2; k++) begin
      req1[k] = 1'b1; a1[k] = 8'hFF; b1[k] = 8'h01; c_in1[k] = 1'b0; sel1[k] = 1'b0;
    end
    repeat (8) cycle();

    // reset during WAIT on the LAT=3 instance, then both requesters on release
    req0[1] = 1'b1; rand_ops(1, 0, 1'b0);
    repeat (2) cycle();
    apply_reset(1);
    req0[1] = 1'b1; req1[1] = 1'b1;
    rand_ops(1, 0, 1'b0); rand_ops(1, 1, 1'b0);
    repeat (2) cycle();
    rst_n[1] = 1'b1;
    repeat (14) cycle();

    // late request: req1 rises while req0 is being served
    req0[0] = 1'b1; rand_ops(0, 0, 1'b0);
    cycle();
    req1[0] = 1'b1; rand_ops(0, 1, 1'b0);
    repeat (6) cycle();

    // random traffic on both instances
    autoreq = '1;
    repeat (200) cycle();
    autoreq = '0;
    repeat (14) cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
